// File: rtl/gol_vga_renderer_pkg.sv
// Shared VGA 640x480@60 timing constants and display types for the Game of Life renderer.
package gol_vga_renderer_pkg;

  localparam int CNT_W = 10;

  localparam logic [CNT_W-1:0] H_ACTIVE     = 10'd640;
  localparam logic [CNT_W-1:0] H_FP_END     = 10'd656;
  localparam logic [CNT_W-1:0] H_SYNC_END   = 10'd752;
  localparam logic [CNT_W-1:0] H_TOTAL      = 10'd800;
  localparam logic [CNT_W-1:0] V_ACTIVE     = 10'd480;
  localparam logic [CNT_W-1:0] V_SYNC_START = 10'd490;
  localparam logic [CNT_W-1:0] V_SYNC_END   = 10'd492;
  localparam logic [CNT_W-1:0] V_TOTAL      = 10'd525;

  localparam int BOARD_DIM  = 16;
  localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM;
  localparam int CELL_IDX_W = $clog2(BOARD_DIM);

  typedef enum logic [1:0] {
    PIX_BLANK,
    PIX_GRID,
    PIX_ALIVE,
    PIX_DEAD
  } pix_class_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic rgb_t rgb_from_hex(input logic [11:0] hex);
    return rgb_t'(hex);
  endfunction

endpackage

// File: rtl/gol_vga_renderer_timing.sv
// Pixel-enable divider, horizontal/vertical counters and raw (unregistered) sync/active flags.
module vga_timing_gen
  import gol_vga_renderer_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             ClkPort,
  input  logic             reset,
  output logic             o_pe,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_active,
  output logic             o_hs_n,
  output logic             o_vs_n,
  output logic             o_frame_last
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             w_pe;
  logic             w_h_last;
  logic             w_v_last;

  assign w_pe     = (r_div == DIV_LAST);
  assign w_h_last = (r_hcnt == H_TOTAL - 10'd1);
  assign w_v_last = (r_vcnt == V_TOTAL - 10'd1);

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_pe) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // vcnt only advances on the pe where hcnt wraps.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_pe) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
    end
  end

  assign o_pe         = w_pe;
  assign o_hcnt       = r_hcnt;
  assign o_vcnt       = r_vcnt;
  assign o_active     = (r_hcnt < H_ACTIVE) && (r_vcnt < V_ACTIVE);
  assign o_hs_n       = !((r_hcnt >= H_FP_END) && (r_hcnt < H_SYNC_END));
  assign o_vs_n       = !((r_vcnt >= V_SYNC_START) && (r_vcnt < V_SYNC_END));
  assign o_frame_last = w_h_last && w_v_last;

endmodule

// File: rtl/gol_vga_renderer.sv
// Renders a per-frame snapshot of the 16x16 board as gridded squares centred on a 640x480 VGA screen.
module gol_vga_renderer
  import gol_vga_renderer_pkg::*;
#(
  parameter int          CLK_DIV   = 4,
  parameter int          CELL_LOG2 = 4,
  parameter int          X_OFF     = 192,
  parameter int          Y_OFF     = 112,
  parameter logic [11:0] ALIVE_RGB = 12'h0F0,
  parameter logic [11:0] GRID_RGB  = 12'h444
) (
  input  logic                  ClkPort,
  input  logic                  reset,
  input  logic [BOARD_BITS-1:0] board_i,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  frame_start_o
);

  localparam int AREA = BOARD_DIM << CELL_LOG2;
  localparam logic [CNT_W-1:0] X_LO      = CNT_W'(X_OFF);
  localparam logic [CNT_W-1:0] X_HI      = CNT_W'(X_OFF + AREA);
  localparam logic [CNT_W-1:0] Y_LO      = CNT_W'(Y_OFF);
  localparam logic [CNT_W-1:0] Y_HI      = CNT_W'(Y_OFF + AREA);
  localparam logic [CNT_W-1:0] EDGE      = CNT_W'(AREA - 1);
  localparam logic [CNT_W-1:0] CELL_MASK = CNT_W'((1 << CELL_LOG2) - 1);

  logic                    w_pe;
  logic [CNT_W-1:0]        w_hcnt;
  logic [CNT_W-1:0]        w_vcnt;
  logic                    w_active;
  logic                    w_hs_n;
  logic                    w_vs_n;
  logic                    w_frame_last;

  logic                    w_in_board;
  logic [CNT_W-1:0]        w_bx;
  logic [CNT_W-1:0]        w_by;
  logic [CELL_IDX_W-1:0]   w_col;
  logic [CELL_IDX_W-1:0]   w_row;
  logic [2*CELL_IDX_W-1:0] w_cell_idx;
  logic                    w_grid;
  pix_class_e              w_class;
  rgb_t                    w_rgb;

  logic [BOARD_BITS-1:0]   r_snapshot;
  rgb_t                    r_rgb;
  logic                    r_hs;
  logic                    r_vs;
  logic                    r_frame_start;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .ClkPort      (ClkPort),
    .reset        (reset),
    .o_pe         (w_pe),
    .o_hcnt       (w_hcnt),
    .o_vcnt       (w_vcnt),
    .o_active     (w_active),
    .o_hs_n       (w_hs_n),
    .o_vs_n       (w_vs_n),
    .o_frame_last (w_frame_last)
  );

  // Range is tested on the raw counters so columns left of the board never wrap into it.
  assign w_in_board = (w_hcnt >= X_LO) && (w_hcnt < X_HI) &&
                      (w_vcnt >= Y_LO) && (w_vcnt < Y_HI);
  assign w_bx       = w_hcnt - X_LO;
  assign w_by       = w_vcnt - Y_LO;
  assign w_col      = CELL_IDX_W'(w_bx >> CELL_LOG2);
  assign w_row      = CELL_IDX_W'(w_by >> CELL_LOG2);
  assign w_cell_idx = {w_row, w_col};
  assign w_grid     = ((w_bx & CELL_MASK) == '0) || ((w_by & CELL_MASK) == '0) ||
                      (w_bx == EDGE) || (w_by == EDGE);

  always_comb begin
    w_class = PIX_BLANK;
    if (w_active && w_in_board) begin
      if (w_grid) begin
        w_class = PIX_GRID;
      end else if (r_snapshot[w_cell_idx]) begin
        w_class = PIX_ALIVE;
      end else begin
        w_class = PIX_DEAD;
      end
    end
  end

  always_comb begin
    w_rgb = '0;
    case (w_class)
      PIX_GRID:  w_rgb = rgb_from_hex(GRID_RGB);
      PIX_ALIVE: w_rgb = rgb_from_hex(ALIVE_RGB);
      default:   w_rgb = '0;
    endcase
  end

  // Colour and sync share one register stage so they stay pixel-aligned.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      r_rgb         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_snapshot    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_pe) begin
        r_rgb <= w_rgb;
        r_hs  <= w_hs_n;
        r_vs  <= w_vs_n;
        if (w_frame_last) begin
          r_snapshot    <= board_i;
          r_frame_start <= 1'b1;
        end
      end
    end
  end

  assign vga_r         = r_rgb.r;
  assign vga_g         = r_rgb.g;
  assign vga_b         = r_rgb.b;
  assign vga_hs        = r_hs;
  assign vga_vs        = r_vs;
  assign frame_start_o = r_frame_start;

endmodule
